// File: rtl/mips_pkg.sv
// Shared MEM-stage definitions: load/store opcodes, access sizes and the opcode decoder.
package mips_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        SZ_W = 2'd0,
        SZ_H = 2'd1,
        SZ_B = 2'd2
    } size_e;

    typedef struct packed {
        logic  load;
        logic  store;
        logic  sext;
        size_e size;
    } dec_t;

    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        d = '0;
        case (op)
            OP_LW:  begin d.load  = 1'b1; d.size = SZ_W; end
            OP_LH:  begin d.load  = 1'b1; d.size = SZ_H; d.sext = 1'b1; end
            OP_LHU: begin d.load  = 1'b1; d.size = SZ_H; end
            OP_LB:  begin d.load  = 1'b1; d.size = SZ_B; d.sext = 1'b1; end
            OP_LBU: begin d.load  = 1'b1; d.size = SZ_B; end
            OP_SW:  begin d.store = 1'b1; d.size = SZ_W; end
            OP_SH:  begin d.store = 1'b1; d.size = SZ_H; end
            OP_SB:  begin d.store = 1'b1; d.size = SZ_B; end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Byte-lane steering for the data memory: store byte enables and lane replication,
// load lane extraction with sign or zero extension.
module dm_lane_unit
    import mips_pkg::*;
(
    input  size_e             size_i,
    input  logic [1:0]        ofs_i,
    input  logic              sext_i,
    input  logic [31:0]       wdata_i,
    input  logic [31:0]       rword_i,
    output logic [BE_W-1:0]   be_o,
    output logic [31:0]       wlane_o,
    output logic [31:0]       rdata_o
);

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
        logic signed [7:0]  bs;
        logic signed [31:0] sx;
        bs = b;
        sx = bs;
        return s ? sx : {24'd0, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
        logic signed [15:0] hs;
        logic signed [31:0] sx;
        hs = h;
        sx = hs;
        return s ? sx : {16'd0, h};
    endfunction

    always_comb begin
        be_o    = '0;
        wlane_o = '0;
        rdata_o = '0;
        case (size_i)
            SZ_W: begin
                be_o    = 4'b1111;
                wlane_o = wdata_i;
                rdata_o = rword_i;
            end
            SZ_H: begin
                be_o    = ofs_i[1] ? 4'b1100 : 4'b0011;
                wlane_o = {2{wdata_i[15:0]}};
                rdata_o = ext16(ofs_i[1] ? rword_i[31:16] : rword_i[15:0], sext_i);
            end
            SZ_B: begin
                be_o    = 4'b0001 << ofs_i;
                wlane_o = {4{wdata_i[7:0]}};
                rdata_o = ext8(rword_i[{ofs_i, 3'b000} +: 8], sext_i);
            end
            default: begin
                be_o    = '0;
                wlane_o = '0;
                rdata_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_dm.sv
// MEM-stage data memory: byte/half/word loads and stores plus a registered store trace.
// Define DM_ALIGN_CHECK_EN to flag and suppress misaligned accesses (exc_adel/exc_ades).
module mem_stage_dm
    import mips_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] ins_M,
    input  logic [31:0] PC_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    output logic [31:0] rdata_M,
    output logic        trace_vld,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic        exc_adel,
    output logic        exc_ades
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    dec_t                  dec;
    logic [31:0]           offs;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           rd_arr [DEPTH];
    logic [31:0]           rword;
    logic [BE_W-1:0]       be;
    logic [31:0]           wlane;
    logic [31:0]           lane_rdata;
    logic [31:0]           merged;
    logic                  mis;
    logic                  commit;

    logic        trace_vld_q,  trace_vld_d;
    logic [31:0] trace_pc_q,   trace_pc_d;
    logic [31:0] trace_addr_q, trace_addr_d;
    logic [31:0] trace_data_q, trace_data_d;

    logic unused_bits;

    assign dec   = decode_op(ins_M[31:26]);
    assign offs  = addr_M - BASE_ADDR;
    // Upper offset bits are dropped on purpose so out-of-range addresses wrap.
    assign idx   = offs[DEPTH_LOG2+1:2];
    assign rword = rd_arr[idx];
    assign unused_bits = ^{ins_M[25:0], offs[31:DEPTH_LOG2+2], offs[1:0]};

    dm_lane_unit u_lane (
        .size_i  (dec.size),
        .ofs_i   (addr_M[1:0]),
        .sext_i  (dec.sext),
        .wdata_i (wdata_M),
        .rword_i (rword),
        .be_o    (be),
        .wlane_o (wlane),
        .rdata_o (lane_rdata)
    );

`ifdef DM_ALIGN_CHECK_EN
    always_comb begin
        mis = 1'b0;
        case (dec.size)
            SZ_W:    mis = (addr_M[1:0] != 2'b00);
            SZ_H:    mis = addr_M[0];
            default: mis = 1'b0;
        endcase
        mis = mis & (dec.load | dec.store);
    end
`else
    assign mis = 1'b0;
`endif

    assign exc_adel = dec.load & mis;
    assign exc_ades = dec.store & mis;
    assign rdata_M  = (dec.load && !mis) ? lane_rdata : 32'd0;
    assign commit   = en & dec.store & ~mis;

    always_comb begin
        merged = rword;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) merged[8*b +: 8] = wlane[8*b +: 8];
        end
    end

    // One register per word keeps the asynchronous clear of the whole array simple.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic [31:0] word_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                word_q <= '0;
            end else if (commit && (idx == DEPTH_LOG2'(g))) begin
                word_q <= merged;
            end
        end
        assign rd_arr[g] = word_q;
    end

    always_comb begin
        trace_vld_d  = commit;
        trace_pc_d   = commit ? PC_M                  : trace_pc_q;
        trace_addr_d = commit ? {addr_M[31:2], 2'b00} : trace_addr_q;
        trace_data_d = commit ? merged                : trace_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trace_vld_q  <= 1'b0;
            trace_pc_q   <= '0;
            trace_addr_q <= '0;
            trace_data_q <= '0;
        end else if (en) begin
            trace_vld_q  <= trace_vld_d;
            trace_pc_q   <= trace_pc_d;
            trace_addr_q <= trace_addr_d;
            trace_data_q <= trace_data_d;
        end
    end

    assign trace_vld  = trace_vld_q;
    assign trace_pc   = trace_pc_q;
    assign trace_addr = trace_addr_q;
    assign trace_data = trace_data_q;

endmodule

// File: tb/tb_mem_stage_dm.sv
// Self-checking bench for mem_stage_dm: byte-level memory model plus directed literal checks.
// Honours DM_ALIGN_CHECK_EN the same way the design does.
module tb_mem_stage_dm;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0;

    localparam logic [5:0] T_LW  = 6'b100011, T_LH  = 6'b100001, T_LHU = 6'b100101;
    localparam logic [5:0] T_LB  = 6'b100000, T_LBU = 6'b100100;
    localparam logic [5:0] T_SW  = 6'b101011, T_SH  = 6'b101001, T_SB  = 6'b101000;
    localparam logic [5:0] T_NOP = 6'b000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [31:0] ins_M = '0, PC_M = '0, addr_M = '0, wdata_M = '0;
    logic [31:0] rdata_M, trace_pc, trace_addr, trace_data;
    logic        trace_vld, exc_adel, exc_ades;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    logic [31:0] mm [DEPTH];
    logic        m_vld;
    logic [31:0] m_pc, m_addr, m_data;

    mem_stage_dm dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .ins_M      (ins_M),
        .PC_M       (PC_M),
        .addr_M     (addr_M),
        .wdata_M    (wdata_M),
        .rdata_M    (rdata_M),
        .trace_vld  (trace_vld),
        .trace_pc   (trace_pc),
        .trace_addr (trace_addr),
        .trace_data (trace_data),
        .exc_adel   (exc_adel),
        .exc_ades   (exc_ades)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%08h required=%08h @%0t", nm, act, exp, $time);
        end
    endfunction

    // Access kind, size in bytes and signedness from the opcode.
    task automatic mdec(input logic [5:0] op, output bit ld, output bit st, output bit sx, output int nb);
        ld = 0; st = 0; sx = 0; nb = 4;
        case (op)
            T_LW:  begin ld = 1; nb = 4; end
            T_LH:  begin ld = 1; nb = 2; sx = 1; end
            T_LHU: begin ld = 1; nb = 2; end
            T_LB:  begin ld = 1; nb = 1; sx = 1; end
            T_LBU: begin ld = 1; nb = 1; end
            T_SW:  begin st = 1; nb = 4; end
            T_SH:  begin st = 1; nb = 2; end
            T_SB:  begin st = 1; nb = 1; end
            default: ;
        endcase
    endtask

    function automatic int m_index(input logic [31:0] a);
        return int'(((a - BASE) >> 2) & 32'(DEPTH - 1));
    endfunction

    function automatic bit m_mis(input logic [31:0] a, input int nb);
`ifdef DM_ALIGN_CHECK_EN
        return (int'(a[1:0]) % nb) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] a,
                                            input logic [31:0] d, input int nb);
        logic [31:0] r;
        int lo;
        r  = old;
        lo = (int'(a[1:0]) / nb) * nb;
        for (int k = 0; k < nb; k++) r[8*(lo+k) +: 8] = d[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                           input int nb, input bit sx);
        logic [31:0] v, mask;
        int lo;
        lo = (int'(a[1:0]) / nb) * nb;
        v  = w >> (8*lo);
        if (nb < 4) begin
            mask = (32'd1 << (8*nb)) - 32'd1;
            v    = v & mask;
            if (sx && v[8*nb-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        m_vld = 0; m_pc = '0; m_addr = '0; m_data = '0;
    endtask

    // Applies the effect of one clock edge using the inputs held across it.
    task automatic model_edge();
        bit ld, st, sx;
        int nb, ix;
        logic [31:0] w;
        if (reset || !en) return;
        mdec(ins_M[31:26], ld, st, sx, nb);
        m_vld = 0;
        if (st && !m_mis(addr_M, nb)) begin
            ix     = m_index(addr_M);
            w      = m_merge(mm[ix], addr_M, wdata_M, nb);
            mm[ix] = w;
            m_vld  = 1;
            m_pc   = PC_M;
            m_addr = {addr_M[31:2], 2'b00};
            m_data = w;
        end
    endtask

    always @(negedge clk) begin
        bit ld, st, sx;
        int nb;
        bit mis;
        logic [31:0] exp_rd;
        if (chk_on && !reset) begin
            mdec(ins_M[31:26], ld, st, sx, nb);
            mis    = m_mis(addr_M, nb);
            exp_rd = (ld && !mis) ? m_load(mm[m_index(addr_M)], addr_M, nb, sx) : 32'd0;
            chk("cmp_rdata", rdata_M, exp_rd);
            chk("cmp_adel", {31'd0, exc_adel}, {31'd0, ld && mis});
            chk("cmp_ades", {31'd0, exc_ades}, {31'd0, st && mis});
            chk("cmp_tvld", {31'd0, trace_vld}, {31'd0, m_vld});
            chk("cmp_tpc", trace_pc, m_pc);
            chk("cmp_taddr", trace_addr, m_addr);
            chk("cmp_tdata", trace_data, m_data);
        end
    end

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                         input bit e, input logic [31:0] pc);
        @(posedge clk);
        model_edge();
        #1;
        ins_M   = {op, 26'h0};
        addr_M  = a;
        wdata_M = d;
        en      = e;
        PC_M    = pc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_on = 1'b1;
        chk("rst_tvld", {31'd0, trace_vld}, 32'd0);
        chk("rst_tdata", trace_data, 32'd0);

        // Reset state then a load from address 0
        drive(T_LW, 32'h0, 32'h0, 1, 32'h100);
        @(negedge clk);
        chk("t1_lw0", rdata_M, 32'h0);
        chk("t1_tvld", {31'd0, trace_vld}, 32'd0);

        // Word store then read back with trace
        drive(T_SW, 32'h10, 32'h12345678, 1, 32'h104);
        drive(T_LW, 32'h10, 32'h0, 1, 32'h108);
        @(negedge clk);
        chk("t2_lw", rdata_M, 32'h12345678);
        chk("t2_tvld", {31'd0, trace_vld}, 32'd1);
        chk("t2_taddr", trace_addr, 32'h10);
        chk("t2_tpc", trace_pc, 32'h104);

        // Byte store into lane 3
        drive(T_SB, 32'h13, 32'h000000AB, 1, 32'h10C);
        drive(T_LB, 32'h13, 32'h0, 1, 32'h110);
        @(negedge clk);
        chk("t3_lb", rdata_M, 32'hFFFFFFAB);
        chk("t3_tdata", trace_data, 32'hAB345678);
        drive(T_LBU, 32'h13, 32'h0, 1, 32'h114);
        @(negedge clk);
        chk("t3_lbu", rdata_M, 32'h000000AB);
        drive(T_LW, 32'h10, 32'h0, 1, 32'h118);
        @(negedge clk);
        chk("t3_lw", rdata_M, 32'hAB345678);

        // Upper halfword store
        drive(T_SH, 32'h12, 32'h00008001, 1, 32'h11C);
        drive(T_LH, 32'h12, 32'h0, 1, 32'h120);
        @(negedge clk);
        chk("t4_lh", rdata_M, 32'hFFFF8001);
        drive(T_LHU, 32'h12, 32'h0, 1, 32'h124);
        @(negedge clk);
        chk("t4_lhu", rdata_M, 32'h00008001);
        drive(T_LW, 32'h10, 32'h0, 1, 32'h128);
        @(negedge clk);
        chk("t4_lw", rdata_M, 32'h80015678);

        // Byte lane 0 from a wide source and a positive signed byte
        drive(T_SB, 32'h20, 32'h1234567F, 1, 32'h12C);
        drive(T_LB, 32'h20, 32'h0, 1, 32'h130);
        @(negedge clk);
        chk("t4_lb_pos", rdata_M, 32'h0000007F);
        drive(T_NOP, 32'h10, 32'h0, 1, 32'h134);
        @(negedge clk);
        chk("t4_nop_rd", rdata_M, 32'h0);

        // Wrap-around addressing, then a frozen store
        drive(T_SW, 32'h4010, 32'hDEADBEEF, 1, 32'h138);
        drive(T_SW, 32'h10, 32'h11111111, 0, 32'h13C);
        drive(T_LW, 32'h10, 32'h0, 1, 32'h140);
        @(negedge clk);
        chk("t5_wrap", rdata_M, 32'hDEADBEEF);
        chk("t5_hold_vld", {31'd0, trace_vld}, 32'd1);
        chk("t5_hold_pc", trace_pc, 32'h138);
        chk("t5_taddr", trace_addr, 32'h4010);

        // Misaligned store and load
        drive(T_SW, 32'h12, 32'hCAFEF00D, 1, 32'h144);
        @(negedge clk);
`ifdef DM_ALIGN_CHECK_EN
        chk("t6_ades", {31'd0, exc_ades}, 32'd1);
`else
        chk("t6_ades", {31'd0, exc_ades}, 32'd0);
`endif
        drive(T_LH, 32'h11, 32'h0, 1, 32'h148);
        @(negedge clk);
`ifdef DM_ALIGN_CHECK_EN
        chk("t6_adel", {31'd0, exc_adel}, 32'd1);
        chk("t6_lh_rd", rdata_M, 32'h0);
        chk("t6_tvld", {31'd0, trace_vld}, 32'd0);
`else
        chk("t6_adel", {31'd0, exc_adel}, 32'd0);
        chk("t6_lh_rd", rdata_M, 32'hFFFFF00D);
        chk("t6_tvld", {31'd0, trace_vld}, 32'd1);
`endif
        drive(T_LW, 32'h10, 32'h0, 1, 32'h14C);
        @(negedge clk);
`ifdef DM_ALIGN_CHECK_EN
        chk("t6_word", rdata_M, 32'hDEADBEEF);
`else
        chk("t6_word", rdata_M, 32'hCAFEF00D);
`endif

        // Asynchronous reset between clocks, held across a store edge
        drive(T_SW, 32'h10, 32'h55AA55AA, 1, 32'h200);
        drive(T_LW, 32'h10, 32'h0, 1, 32'h204);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t7_async_tvld", {31'd0, trace_vld}, 32'd0);
        chk("t7_async_rd", rdata_M, 32'h0);
        chk("t7_async_tpc", trace_pc, 32'h0);
        ins_M   = {T_SW, 26'h0};
        wdata_M = 32'h77777777;
        PC_M    = 32'h208;
        drive(T_LW, 32'h10, 32'h0, 1, 32'h20C);
        @(negedge clk);
        #1 reset = 1'b0;
        drive(T_LW, 32'h10, 32'h0, 1, 32'h210);
        @(negedge clk);
        chk("t7_discard", rdata_M, 32'h0);
        chk("t7_tvld", {31'd0, trace_vld}, 32'd0);
        drive(T_SW, 32'h10, 32'h0BADF00D, 1, 32'h214);
        drive(T_LW, 32'h10, 32'h0, 1, 32'h218);
        @(negedge clk);
        chk("t7_recover", rdata_M, 32'h0BADF00D);

        drive(T_NOP, 32'h0, 32'h0, 1, 32'h21C);
        @(negedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
